// File: rtl/demux_1x4_reg_if.sv
// rtl/demux_1x4_reg_if.sv - producer/consumer bus for the registered 1-to-4 demux
// Signals:
//   in_valid/in_ready/sel/in_data  producer handshake, destination slot and payload
//   out_valid/out_ready            per-slot handshake, bit k belongs to slot k
//   out_data0..3                   registered slot contents
//   xfer_cnt                       accepted-word counter, modulo 256
// Modports: master = producer/consumer side, slave = demux side.
interface demux_1x4_reg_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       sel;
  logic [WIDTH-1:0] in_data;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [WIDTH-1:0] out_data0;
  logic [WIDTH-1:0] out_data1;
  logic [WIDTH-1:0] out_data2;
  logic [WIDTH-1:0] out_data3;
  logic [7:0]       xfer_cnt;

  modport master (
    output in_valid, sel, in_data, out_ready,
    input  in_ready, out_valid, out_data0, out_data1, out_data2, out_data3, xfer_cnt
  );

  modport slave (
    input  in_valid, sel, in_data, out_ready,
    output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3, xfer_cnt
  );
endinterface

// File: rtl/demux_1x4_reg.sv
// rtl/demux_1x4_reg.sv - registered 1-to-4 demux with per-slot valid/ready handshake
// Ports:
//   clk    sole clock, rising edge
//   reset  synchronous active-high reset
//   bus    demux_1x4_reg_if slave modport (input handshake, four output slots, counter)
module demux_1x4_reg #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            reset,
  demux_1x4_reg_if.slave  bus
);

  logic [3:0]       valid_q, valid_d;
  logic [WIDTH-1:0] data_q [4];
  logic [WIDTH-1:0] data_d [4];
  logic [7:0]       cnt_q, cnt_d;

  logic             in_ready;
  logic             accept;
  logic [3:0]       load;
  logic [3:0]       drain;

  // Ready looks only at the selected slot: free, or being drained this cycle.
  assign in_ready = reset ? 1'b0 : (!valid_q[bus.sel] || bus.out_ready[bus.sel]);
  assign accept   = bus.in_valid && in_ready;
  assign load     = accept ? (4'b0001 << bus.sel) : 4'b0000;
  // Ready on an empty slot is masked out here, so it has no effect.
  assign drain    = valid_q & bus.out_ready;

  always_comb begin
    valid_d = valid_q;
    cnt_d   = cnt_q;
    for (int k = 0; k < 4; k++) begin
      data_d[k] = data_q[k];
      // Load takes priority over drain so a slot sustains one word per cycle.
      if (load[k]) begin
        valid_d[k] = 1'b1;
        data_d[k]  = bus.in_data;
      end else if (drain[k]) begin
        valid_d[k] = 1'b0;
      end
    end
    if (accept) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 4'b0000;
      cnt_q   <= 8'd0;
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.out_data0 = data_q[0];
  assign bus.out_data1 = data_q[1];
  assign bus.out_data2 = data_q[2];
  assign bus.out_data3 = data_q[3];
  assign bus.xfer_cnt  = cnt_q;

endmodule
